// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply/multiply-accumulate unit.
// Also used by the ALU control and hazard unit.
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_BUSY = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_t;

  localparam int MAC_DATA_W = 32;
  localparam int MAC_ACC_W  = 64;

endpackage

// File: rtl/mac_acc_add.sv
// Accumulator next-value logic: clear mux followed by an ACC_W adder.
// Defining MAC_SAT_EN makes the add saturate to all ones instead of wrapping.
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  input  logic             add_en,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_next
);

`ifdef MAC_SAT_EN
  function automatic logic [ACC_W-1:0] acc_sum(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] acc_sum(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return a + b;
  endfunction
`endif

  logic [ACC_W-1:0] base;

  // A clear coinciding with an accumulate leaves just the new product.
  always_comb begin
    base     = clr ? '0 : acc;
    acc_next = add_en ? acc_sum(base, addend) : base;
  end

endmodule

// File: rtl/mac_unit.sv
// Multi-cycle shift-add multiplier with optional accumulate into a persistent
// accumulator; MAC_SAT_EN selects saturating instead of wrapping accumulation.
module mac_unit
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mac_select,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ACC_W-1:0]  acc,
  output logic              busy
);

  localparam int              PW       = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mac_state_t        state, state_next;
  logic [PW-1:0]     mcand;
  logic [DATA_W-1:0] mplier;
  logic [PW-1:0]     product;
  logic [PW-1:0]     product_next;
  logic [CNT_W-1:0]  cnt;
  logic              is_mac;
  logic              accept;
  logic              last;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_next;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= MAC_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MAC_IDLE: if (in_valid)  state_next = MAC_BUSY;
      MAC_BUSY: if (last)      state_next = MAC_DONE;
      MAC_DONE: if (out_ready) state_next = MAC_IDLE;
      default:                 state_next = MAC_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, keeping inputs off the ready path.
  always_comb begin
    in_ready = (state == MAC_IDLE);
    busy     = (state != MAC_IDLE);
  end

  assign accept       = in_ready & in_valid;
  assign last         = (state == MAC_BUSY) && (cnt == CNT_LAST);
  assign product_next = product + (mplier[0] ? mcand : '0);

  always_comb begin
    addend        = '0;
    addend[PW-1:0] = product_next;
  end

  mac_acc_add #(.ACC_W(ACC_W)) u_acc_add (
    .acc      (acc),
    .addend   (addend),
    .add_en   (last & is_mac),
    .clr      (acc_clr),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      cnt       <= '0;
      is_mac    <= 1'b0;
      result    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      acc <= acc_next;
      if (accept) begin
        mcand   <= PW'(op_a);
        mplier  <= op_b;
        is_mac  <= mac_select;
        product <= '0;
        cnt     <= '0;
      end else if (state == MAC_BUSY) begin
        product <= product_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        cnt     <= cnt + CNT_W'(1);
        if (last) result <= is_mac ? acc_next[DATA_W-1:0] : product_next[DATA_W-1:0];
      end
      if (last)                                out_valid <= 1'b1;
      else if (state == MAC_DONE && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit (DATA_W=32, ACC_W=64); honours MAC_SAT_EN.
module tb_mac_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mac_select;
  logic        acc_clr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [63:0] acc;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic [63:0] acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [63:0] model_acc;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mac_unit #(.DATA_W(32), .ACC_W(64)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mac_select (mac_select),
    .acc_clr    (acc_clr),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .acc        (acc),
    .busy       (busy)
  );

  function automatic logic [63:0] model_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef MAC_SAT_EN
    if (s[64]) return 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    return s[63:0];
  endfunction

  task automatic expect_op(input logic [31:0] a, input logic [31:0] b,
                           input bit mac, input bit clr_coll);
    logic [63:0] prod;
    exp_t x;
    prod = {32'd0, a} * {32'd0, b};
    if (mac) begin
      model_acc = clr_coll ? prod : model_add(model_acc, prod);
      x.res = model_acc[31:0];
    end else begin
      x.res = prod[31:0];
    end
    x.acc = model_acc;
    sbq.push_back(x);
  endtask

  // Drive one request from IDLE; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input bit mac, input bit clr_coll);
    expect_op(a, b, mac, clr_coll);
    op_a = a; op_b = b; mac_select = mac; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    arst_n = 1'b0; in_valid = 1'b0; mac_select = 1'b0; acc_clr = 1'b0;
    op_a = '0; op_b = '0; out_ready = 1'b1; model_acc = '0;
    #3;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== 64'd0 || result !== 32'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b acc=%h result=%h busy=%b want 1 0 0 0 0",
               in_ready, out_valid, acc, result, busy);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    int lat;
    issue(32'd7, 32'd6, 1'b0, 1'b0);
    wait_out(lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 32) begin bad++; $display("FAIL mul_latency: got %0d want 32", lat); end
    total++;
    if (result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL mul_result: got res=%h acc=%h want res=%h acc=%h", result, acc, e.res, e.acc);
    end
    @(negedge clk);
  endtask

  task automatic test_mac_chain;
    int lat, k;
    issue(32'd3, 32'd4, 1'b1, 1'b0);
    // Second request held high throughout the first operation.
    expect_op(32'd5, 32'd5, 1'b1, 1'b0);
    op_a = 32'd5; op_b = 32'd5; mac_select = 1'b1; in_valid = 1'b1;
    wait_out(lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 32 || result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL mac_first: lat=%0d res=%h acc=%h want lat=32 res=%h acc=%h", lat, result, acc, e.res, e.acc);
    end
    k = 0;
    while (!in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== 1) begin bad++; $display("FAIL mac_reaccept: got %0d cycles want 1", k); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 32 || result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL mac_second: lat=%0d res=%h acc=%h want lat=32 res=%h acc=%h", lat, result, acc, e.res, e.acc);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    issue(32'd9, 32'd9, 1'b0, 1'b0);
    wait_out(lat);
    e = sbq.pop_front();
    total++;
    if (result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL bp_result: got res=%h acc=%h want res=%h acc=%h", result, acc, e.res, e.acc);
    end
    op_a = 32'd1; op_b = 32'd1; mac_select = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || result !== e.res || acc !== e.acc || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b res=%h acc=%h in_ready=%b want 1 %h %h 0",
                 i, out_valid, result, acc, in_ready, e.res, e.acc);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc !== e.acc) begin
      bad++; $display("FAIL bp_exit: out_valid=%b in_ready=%b acc=%h want 0 1 %h", out_valid, in_ready, acc, e.acc);
    end
  endtask

  task automatic test_abort;
    int lat;
    issue(32'd7, 32'd7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    void'(sbq.pop_back());
    model_acc = '0;
    total++;
    if (out_valid !== 1'b0 || acc !== 64'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort: out_valid=%b acc=%h in_ready=%b busy=%b want 0 0 1 0", out_valid, acc, in_ready, busy);
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    issue(32'd3, 32'd7, 1'b0, 1'b0);
    wait_out(lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 32 || result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL abort_recover: lat=%0d res=%h acc=%h want lat=32 res=%h acc=%h", lat, result, acc, e.res, e.acc);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      wait_out(lat);
      e = sbq.pop_front();
      total++;
      if (lat !== 32 || result !== e.res || acc !== e.acc) begin
        bad++; $display("FAIL overflow[%0d]: lat=%0d res=%h acc=%h want lat=32 res=%h acc=%h", i, lat, result, acc, e.res, e.acc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_acc_clr;
    int lat;
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    model_acc = '0;
    total++;
    if (acc !== 64'd0) begin bad++; $display("FAIL clr_idle_a: got acc=%h want 0", acc); end
    issue(32'd10, 32'd10, 1'b1, 1'b0);
    wait_out(lat);
    e = sbq.pop_front();
    total++;
    if (result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL clr_setup: res=%h acc=%h want res=%h acc=%h", result, acc, e.res, e.acc);
    end
    @(negedge clk);
    issue(32'd2, 32'd3, 1'b1, 1'b1);
    repeat (31) @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    e = sbq.pop_front();
    total++;
    if (out_valid !== 1'b1 || result !== e.res || acc !== e.acc) begin
      bad++; $display("FAIL clr_collision: out_valid=%b res=%h acc=%h want 1 res=%h acc=%h", out_valid, result, acc, e.res, e.acc);
    end
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    total++;
    if (acc !== 64'd0) begin bad++; $display("FAIL clr_idle_b: got acc=%h want 0", acc); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mac_chain();
    test_backpressure();
    test_abort();
    test_overflow();
    test_acc_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
